// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32 immediate decoder feeding a 2-entry valid/ready FIFO.
// The decode is combinational on the input. The decoded entry is captured
// on the input handshake and presented one cycle later. in_ready depends
// only on registered occupancy, so no combinational path runs from
// out_ready to in_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    input  logic [2:0]       imm_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       out_sel,
    output logic             illegal,
    output logic [CNT_W-1:0] imm_count
);

    localparam logic [2:0] SEL_R = 3'b000;
    localparam logic [2:0] SEL_I = 3'b001;
    localparam logic [2:0] SEL_B = 3'b010;
    localparam logic [2:0] SEL_S = 3'b011;
    localparam logic [2:0] SEL_U = 3'b100;
    localparam logic [2:0] SEL_J = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      sel;
        logic            illegal;
    } entry_t;

    logic [31:0]     raw32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;

    entry_t          entry_q [2];
    entry_t          entry_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            push;
    logic            pop;
    entry_t          head;

    // Decode the immediate as a 32-bit sign-extended value, then widen to XLEN.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        raw32       = '0;
        dec_illegal = 1'b0;
        case (imm_sel)
            SEL_R: raw32 = '0;
            SEL_I: raw32 = {{20{instruction[31]}}, instruction[31:20]};
            SEL_S: raw32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            SEL_B: raw32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            SEL_U: raw32 = {instruction[31:12], 12'b0};
            SEL_J: raw32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            default: dec_illegal = 1'b1;
        endcase
        dec_imm        = {XLEN{raw32[31]}};
        dec_imm[31:0]  = raw32;
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = entry_q[rd_ptr_q];

    // Outputs read as zero while the FIFO is empty, so stale storage never shows.
    assign imm       = out_valid ? head.imm     : '0;
    assign out_sel   = out_valid ? head.sel     : '0;
    assign illegal   = out_valid ? head.illegal : 1'b0;
    assign imm_count = cnt_q;

    // Next-state for FIFO storage, pointers, occupancy and handshake counter.
    always_comb begin
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        if (push) begin
            entry_d[wr_ptr_q] = '{imm: dec_imm, sel: imm_sel, illegal: dec_illegal};
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            cnt_d    = cnt_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state: synchronous active-low reset empties the FIFO and clears the counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; occupancy gates every read, so its contents never matter when empty.
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe. Three instances share one stimulus
// stream: XLEN=32/CNT_W=16, XLEN=64, and CNT_W=4 for counter wrap.
// A queue-based reference model predicts every output.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic [2:0]  imm_sel;
    logic        out_ready;

    logic        in_ready, out_valid, illegal;
    logic [31:0] imm;
    logic [2:0]  out_sel;
    logic [15:0] imm_count;

    logic        in_ready64, out_valid64, illegal64;
    logic [63:0] imm64;
    logic [2:0]  out_sel64;
    logic [15:0] imm_count64;

    logic        in_ready4, out_valid4, illegal4;
    logic [31:0] imm4;
    logic [2:0]  out_sel4;
    logic [3:0]  imm_count4;

    int checks   = 0;
    int failures = 0;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .imm_sel(imm_sel), .out_valid(out_valid),
        .out_ready(out_ready), .imm(imm), .out_sel(out_sel), .illegal(illegal),
        .imm_count(imm_count));

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .instruction(instruction), .imm_sel(imm_sel), .out_valid(out_valid64),
        .out_ready(out_ready), .imm(imm64), .out_sel(out_sel64), .illegal(illegal64),
        .imm_count(imm_count64));

    imm_gen_pipe #(.XLEN(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .instruction(instruction), .imm_sel(imm_sel), .out_valid(out_valid4),
        .out_ready(out_ready), .imm(imm4), .out_sel(out_sel4), .illegal(illegal4),
        .imm_count(imm_count4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint unsigned imm;
        bit [2:0]        sel;
        bit              ill;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt = 0;

    // Reference decode: extract the immediate field as an unsigned number,
    // scale it, then reinterpret as signed of the format's width.
    function automatic void ref_decode(input bit [31:0] i, input bit [2:0] s,
                                       output longint unsigned v, output bit ill);
        longint f;
        int     w;
        ill = 0;
        f   = 0;
        w   = 1;
        case (s)
            3'd0: begin f = 0; w = 1; end
            3'd1: begin f = longint'(i[31:20]); w = 12; end
            3'd3: begin f = longint'({i[31:25], i[11:7]}); w = 12; end
            3'd2: begin f = longint'({i[31], i[7], i[30:25], i[11:8]}) * 2; w = 13; end
            3'd4: begin f = longint'(i[31:12]) * 4096; w = 32; end
            3'd5: begin f = longint'({i[31], i[19:12], i[20], i[30:21]}) * 2; w = 21; end
            default: begin f = 0; w = 1; ill = 1; end
        endcase
        if (w > 1 && f >= (64'sd1 <<< (w - 1))) f = f - (64'sd1 <<< w);
        v = longint'(f);
    endfunction

    // Advance one clock, updating the model with this cycle's handshakes.
    // Returns #1 after the edge, where outputs are sampled and inputs changed.
    task automatic cycle();
        bit   push, pop;
        exp_t e;
        push = in_valid && (exp_q.size() < 2);
        pop  = out_ready && (exp_q.size() > 0);
        ref_decode(instruction, imm_sel, e.imm, e.ill);
        e.sel = imm_sel;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                m_cnt++;
            end
            if (push) exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; in_valid = 0; out_ready = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 1; out_ready = 1;
        instruction = 32'hFFF00093; imm_sel = 3'b001;
        cycle();
        cycle();
        checks++;
        if (out_valid !== 1'b0 || imm !== 32'h0 || out_sel !== 3'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b imm=%h sel=%b ill=%b expected 0/0/0/0",
                     out_valid, imm, out_sel, illegal);
        end
        checks++;
        if (imm_count !== 16'd0 || imm_count4 !== 4'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d/%0d expected 0", imm_count, imm_count4);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1; in_valid = 0;
        cycle();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        bit [31:0] vin [5]  = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'h00000033};
        bit [2:0]  vsel[5]  = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b000};
        bit [31:0] vexp[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h0};
        do_reset();
        out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1; instruction = vin[k]; imm_sel = vsel[k];
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL directed_empty_%0d: got out_valid=%b expected 0", k, out_valid);
            end
            cycle();
            in_valid = 0;
            checks++;
            if (out_valid !== 1'b1 || imm !== vexp[k] || illegal !== 1'b0 || out_sel !== vsel[k]) begin
                failures++;
                $display("FAIL directed_%0d: got valid=%b imm=%h sel=%b ill=%b expected 1/%h/%b/0",
                         k, out_valid, imm, out_sel, illegal, vexp[k], vsel[k]);
            end
            checks++;
            if (imm64 !== {{32{vexp[k][31]}}, vexp[k]}) begin
                failures++;
                $display("FAIL directed64_%0d: got %h expected %h", k, imm64, {{32{vexp[k][31]}}, vexp[k]});
            end
            cycle();
        end
        checks++;
        if (imm_count !== 16'd5) begin
            failures++;
            $display("FAIL directed_count: got %0d expected 5", imm_count);
        end
    endtask

    task automatic test_illegal();
        bit [2:0] s;
        do_reset();
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            s = (k % 2 == 0) ? 3'b110 : 3'b111;
            in_valid = 1; instruction = $urandom; imm_sel = s;
            cycle();
            in_valid = 0;
            checks++;
            if (out_valid !== 1'b1 || imm !== 32'h0 || imm64 !== 64'h0 || illegal !== 1'b1 || out_sel !== s) begin
                failures++;
                $display("FAIL illegal_%0d: got valid=%b imm=%h sel=%b ill=%b expected 1/0/%b/1",
                         k, out_valid, imm, out_sel, illegal, s);
            end
            cycle();
            checks++;
            if (imm_count !== 16'(k + 1)) begin
                failures++;
                $display("FAIL illegal_count_%0d: got %0d expected %0d", k, imm_count, k + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        bit [31:0] bin [3] = '{32'hFFF00093, 32'hFE112E23, 32'h123450B7};
        bit [2:0]  bsel[3] = '{3'b001, 3'b011, 3'b100};
        bit        rdy_exp[3] = '{1'b1, 1'b0, 1'b0};
        longint unsigned v;
        bit ill;
        do_reset();
        out_ready = 0;
        in_valid  = 1;
        ref_decode(bin[0], bsel[0], v, ill);
        for (int k = 0; k < 3; k++) begin
            instruction = bin[k]; imm_sel = bsel[k];
            cycle();
            checks++;
            if (in_ready !== rdy_exp[k]) begin
                failures++;
                $display("FAIL bp_in_ready_%0d: got %b expected %b", k, in_ready, rdy_exp[k]);
            end
            checks++;
            if (out_valid !== 1'b1 || imm !== v[31:0] || out_sel !== bsel[0]) begin
                failures++;
                $display("FAIL bp_stable_%0d: got imm=%h sel=%b expected %h/%b",
                         k, imm, out_sel, v[31:0], bsel[0]);
            end
        end
        in_valid = 0;
        out_ready = 1;
        for (int k = 0; k < 2; k++) begin
            ref_decode(bin[k], bsel[k], v, ill);
            checks++;
            if (out_valid !== 1'b1 || imm !== v[31:0] || out_sel !== bsel[k]) begin
                failures++;
                $display("FAIL bp_drain_%0d: got valid=%b imm=%h sel=%b expected 1/%h/%b",
                         k, out_valid, imm, out_sel, v[31:0], bsel[k]);
            end
            cycle();
        end
        checks++;
        if (out_valid !== 1'b0 || imm_count !== 16'd2 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_done: got valid=%b count=%0d in_ready=%b expected 0/2/1",
                     out_valid, imm_count, in_ready);
        end
    endtask

    task automatic test_back_to_back(input int n);
        bit [31:0] ins [$];
        bit [2:0]  sls [$];
        longint unsigned v;
        bit ill;
        int bad = 0;
        do_reset();
        out_ready = 1;
        for (int k = 0; k < n; k++) begin
            ins.push_back($urandom);
            sls.push_back(3'($urandom_range(0, 5)));
        end
        in_valid = 1; instruction = ins[0]; imm_sel = sls[0];
        cycle();
        for (int k = 1; k <= n; k++) begin
            ref_decode(ins[k-1], sls[k-1], v, ill);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || imm !== v[31:0] || out_sel !== sls[k-1]) begin
                failures++;
                bad++;
                $display("FAIL b2b_%0d_%0d: got valid=%b rdy=%b imm=%h sel=%b expected 1/1/%h/%b",
                         n, k - 1, out_valid, in_ready, imm, out_sel, v[31:0], sls[k-1]);
            end
            if (k < n) begin
                instruction = ins[k]; imm_sel = sls[k];
            end else begin
                in_valid = 0;
            end
            cycle();
        end
        checks++;
        if (imm_count !== 16'(n) || imm_count4 !== 4'(n % 16)) begin
            failures++;
            $display("FAIL b2b_count_%0d: got %0d/%0d expected %0d/%0d",
                     n, imm_count, imm_count4, n, n % 16);
        end
    endtask

    task automatic test_reset_held();
        do_reset();
        out_ready = 0; in_valid = 1;
        for (int k = 0; k < 2; k++) begin
            instruction = $urandom; imm_sel = 3'b001;
            cycle();
        end
        out_ready = 1;
        cycle();
        checks++;
        if (imm_count !== 16'd1) begin
            failures++;
            $display("FAIL rh_pre_count: got %0d expected 1", imm_count);
        end
        rst_n = 0;
        cycle();
        checks++;
        if (out_valid !== 1'b0 || imm_count !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rh_reset: got valid=%b count=%0d rdy=%b expected 0/0/1",
                     out_valid, imm_count, in_ready);
        end
        rst_n = 1; in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0 || imm_count !== 16'd0) begin
                failures++;
                $display("FAIL rh_stale_%0d: got valid=%b count=%0d expected 0/0", k, out_valid, imm_count);
            end
        end
    endtask

    task automatic test_random();
        exp_t h;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            instruction = $urandom;
            imm_sel     = 3'($urandom_range(0, 7));
            if (c % 97 == 96) rst_n = 0;
            cycle();
            rst_n = 1;
            checks++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2)
                || imm_count !== 16'(m_cnt) || imm_count4 !== 4'(m_cnt % 16)) begin
                failures++;
                $display("FAIL rand_ctrl_%0d: got valid=%b rdy=%b count=%0d expected %b/%b/%0d",
                         c, out_valid, in_ready, imm_count, exp_q.size() > 0, exp_q.size() < 2, m_cnt);
            end
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                checks++;
                if (imm !== h.imm[31:0] || imm64 !== h.imm || out_sel !== h.sel || illegal !== h.ill) begin
                    failures++;
                    $display("FAIL rand_data_%0d: got imm=%h imm64=%h sel=%b ill=%b expected %h/%h/%b/%b",
                             c, imm, imm64, out_sel, illegal, h.imm[31:0], h.imm, h.sel, h.ill);
                end
            end
        end
    endtask

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 0; instruction = '0; imm_sel = '0;
        test_reset();
        test_directed();
        test_illegal();
        test_backpressure();
        test_back_to_back(10);
        test_back_to_back(17);
        test_reset_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
